// File: rtl/crypto_stim_pkg.sv
// rtl/crypto_stim_pkg.sv - shared status encoding and unlock sequence constants for crypto_stim_driver
package crypto_stim_pkg;

   typedef enum logic [1:0] {
      STAT_UNKNOWN = 2'd0,
      STAT_INVERT  = 2'd1,
      STAT_BYPASS  = 2'd2,
      STAT_ERROR   = 2'd3
   } stat_e;

   localparam logic [7:0] UNLOCK_B0   = 8'h21;
   localparam logic [7:0] UNLOCK_B1   = 8'hF1;
   localparam logic [7:0] UNLOCK_B2   = 8'h37;
   localparam logic [7:0] UNLOCK_TERM = 8'h00;

   function automatic logic [7:0] unlock_byte(input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = UNLOCK_B0;
         2'd1:    b = UNLOCK_B1;
         2'd2:    b = UNLOCK_B2;
         default: b = UNLOCK_TERM;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/stim_fifo.sv
// rtl/stim_fifo.sv - DEPTH-entry synchronous FIFO; the extra occupancy bit separates full from empty
module stim_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      level_d = level_q + LW'(do_push) - LW'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/crypto_stim_driver.sv
// rtl/crypto_stim_driver.sv - drives queued bytes into fake_crypto and classifies its response
// Optional autonomous unlock preload after reset: CRYPTO_STIM_PRELOAD_EN
module crypto_stim_driver
   import crypto_stim_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int HOLD_W   = 4,
   parameter int PRE_HOLD = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [7:0]                wr_data,
   input  logic [HOLD_W-1:0]         wr_hold,
   output logic [7:0]                drv_byte,
   input  logic [7:0]                resp_byte,
   output logic                      busy,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic [1:0]                status,
   output logic                      unlock_seen,
   output logic                      err_sticky
);

   localparam int FW = 8 + HOLD_W;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two of at least 2");
   end
   if (PRE_HOLD < 1 || PRE_HOLD > (1 << HOLD_W)) begin : g_bad_pre_hold
      $error("PRE_HOLD must fit the hold counter");
   end

`ifdef CRYPTO_STIM_PRELOAD_EN
   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PRELOAD} state_e;
   localparam state_e RESET_STATE = S_PRELOAD;
   logic [1:0] pre_idx_q, pre_idx_d;
`else
   typedef enum logic {S_IDLE, S_HOLD} state_e;
   localparam state_e RESET_STATE = S_IDLE;
`endif

   state_e            state_q, state_d;
   logic [7:0]        drv_q, drv_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              started_q, started_d;
   logic [7:0]        prev_drv_q, prev_drv_d;
   logic              prev_valid_q, prev_valid_d;
   stat_e             status_q, status_d;
   logic              unlock_q, unlock_d;
   logic              err_q, err_d;

   logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [FW-1:0]     fifo_rdata;
   logic [HOLD_W-1:0] rd_hold;

   assign wr_ready  = !fifo_full;
   assign fifo_push = wr_valid && wr_ready;
   assign rd_hold   = fifo_rdata[FW-1:8];

   stim_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({wr_hold, wr_data}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_comb begin
      state_d   = state_q;
      drv_d     = drv_q;
      hold_d    = hold_q;
      started_d = started_q;
      fifo_pop  = 1'b0;
`ifdef CRYPTO_STIM_PRELOAD_EN
      pre_idx_d = pre_idx_q;
`endif
      case (state_q)
         S_IDLE, S_HOLD: begin
            if (state_q == S_HOLD && hold_q != '0) begin
               hold_d = hold_q - 1'b1;
            end else if (!fifo_empty) begin
               // a hold of 0 still presents the byte for one cycle
               fifo_pop  = 1'b1;
               drv_d     = fifo_rdata[7:0];
               hold_d    = (rd_hold == '0) ? '0 : rd_hold - 1'b1;
               started_d = 1'b1;
               state_d   = S_HOLD;
            end else begin
               state_d = S_IDLE;
            end
         end
`ifdef CRYPTO_STIM_PRELOAD_EN
         S_PRELOAD: begin
            drv_d     = unlock_byte(pre_idx_q);
            started_d = 1'b1;
            if (hold_q == HOLD_W'(PRE_HOLD - 1)) begin
               hold_d = '0;
               if (pre_idx_q == 2'd3) state_d = S_IDLE;
               else                   pre_idx_d = pre_idx_q + 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // resp_byte reflects what crypto latched from drv_byte on the previous edge
   always_comb begin
      prev_drv_d   = drv_q;
      prev_valid_d = prev_valid_q | started_q;
      status_d     = status_q;
      if (prev_valid_q) begin
         if (resp_byte == ~prev_drv_q)     status_d = STAT_INVERT;
         else if (resp_byte == prev_drv_q) status_d = STAT_BYPASS;
         else                              status_d = STAT_ERROR;
      end
      err_d    = err_q | (status_d == STAT_ERROR);
      unlock_d = unlock_q | (status_q == STAT_INVERT && status_d == STAT_BYPASS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RESET_STATE;
         drv_q        <= '0;
         hold_q       <= '0;
         started_q    <= 1'b0;
         prev_drv_q   <= '0;
         prev_valid_q <= 1'b0;
         status_q     <= STAT_UNKNOWN;
         unlock_q     <= 1'b0;
         err_q        <= 1'b0;
`ifdef CRYPTO_STIM_PRELOAD_EN
         pre_idx_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         drv_q        <= drv_d;
         hold_q       <= hold_d;
         started_q    <= started_d;
         prev_drv_q   <= prev_drv_d;
         prev_valid_q <= prev_valid_d;
         status_q     <= status_d;
         unlock_q     <= unlock_d;
         err_q        <= err_d;
`ifdef CRYPTO_STIM_PRELOAD_EN
         pre_idx_q    <= pre_idx_d;
`endif
      end
   end

   assign drv_byte    = drv_q;
   assign busy        = (state_q != S_IDLE) || !fifo_empty;
   assign status      = status_q;
   assign unlock_seen = unlock_q;
   assign err_sticky  = err_q;

endmodule

// File: tb/tb_crypto_stim_driver.sv
// tb/tb_crypto_stim_driver.sv - directed self-checking bench for crypto_stim_driver with a fake_crypto model
module tb_crypto_stim_driver;
   import crypto_stim_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = '0;
   logic [3:0] wr_hold = '0;
   logic [7:0] drv_byte;
   logic [7:0] resp_byte;
   logic       busy;
   logic [2:0] fifo_level;
   logic [1:0] status;
   logic       unlock_seen;
   logic       err_sticky;

   int vectors = 0;
   int miscompares = 0;

   // fake_crypto model: registered invert, pass-through once unlocked
   logic [7:0] crypto_q;
   logic       unlocked_q;
   logic       unlock_en = 1'b0;
   logic       force_en = 1'b0;
   logic [7:0] force_val = '0;

   logic       mon_en = 1'b0;
   logic [7:0] last_mon;
   logic [7:0] seen[$];

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         crypto_q   <= '0;
         unlocked_q <= 1'b0;
      end else begin
         crypto_q <= unlocked_q ? drv_byte : ~drv_byte;
         if (unlock_en && drv_byte == 8'h44) unlocked_q <= 1'b1;
      end
   end

   assign resp_byte = force_en ? force_val : crypto_q;

   always @(negedge clk) begin
      if (mon_en && drv_byte != last_mon) begin
         seen.push_back(drv_byte);
         last_mon = drv_byte;
      end
   end

   crypto_stim_driver #(.DEPTH(4), .HOLD_W(4), .PRE_HOLD(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .wr_hold     (wr_hold),
      .drv_byte    (drv_byte),
      .resp_byte   (resp_byte),
      .busy        (busy),
      .fifo_level  (fifo_level),
      .status      (status),
      .unlock_seen (unlock_seen),
      .err_sticky  (err_sticky)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_valid = 1'b0;
      unlock_en = 1'b0;
      force_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
      vectors++; if (drv_byte !== 8'h00) begin miscompares++; $display("FAIL reset_drv got %h want 00", drv_byte); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (status !== STAT_UNKNOWN) begin miscompares++; $display("FAIL reset_status got %0d want 0", status); end
      vectors++; if ({unlock_seen, err_sticky} !== 2'b00) begin miscompares++; $display("FAIL reset_sticky got %b want 00", {unlock_seen, err_sticky}); end
      rst = 1'b0;
      tick();
      vectors++; if (busy !== 1'b0 || drv_byte !== 8'h00) begin miscompares++; $display("FAIL reset_idle busy=%b drv=%h want 0/00", busy, drv_byte); end
   endtask

   task automatic test_single_hold();
      do_reset();
      wr_valid = 1'b1; wr_data = 8'h5A; wr_hold = 4'd3;
      tick();
      wr_valid = 1'b0;
      vectors++; if (drv_byte !== 8'h00 || fifo_level !== 3'd1) begin miscompares++; $display("FAIL single_no_bypass drv=%h lvl=%0d want 00/1", drv_byte, fifo_level); end
      tick();
      vectors++; if (drv_byte !== 8'h5A || fifo_level !== 3'd0) begin miscompares++; $display("FAIL single_drive drv=%h lvl=%0d want 5a/0", drv_byte, fifo_level); end
      tick();
      vectors++; if (status !== STAT_UNKNOWN || busy !== 1'b1) begin miscompares++; $display("FAIL single_pre_status status=%0d busy=%b want 0/1", status, busy); end
      tick();
      vectors++; if (status !== STAT_INVERT || busy !== 1'b1 || drv_byte !== 8'h5A) begin miscompares++; $display("FAIL single_invert status=%0d busy=%b drv=%h want 1/1/5a", status, busy, drv_byte); end
      tick();
      vectors++; if (busy !== 1'b0 || status !== STAT_INVERT) begin miscompares++; $display("FAIL single_done busy=%b status=%0d want 0/1", busy, status); end
   endtask

   task automatic test_fill_full();
      logic [7:0] exp_b [6];
      int waited;
      exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      do_reset();
      seen.delete();
      last_mon = 8'h00;
      mon_en = 1'b1;
      wr_hold = 4'd15;
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_data = exp_b[i];
         tick();
      end
      vectors++; if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full lvl=%0d ready=%b want 4/0", fifo_level, wr_ready); end
      wr_data = exp_b[5];
      waited = 0;
      while (!wr_ready && waited < 40) begin tick(); waited++; end
      vectors++; if (waited < 10 || waited >= 40) begin miscompares++; $display("FAIL fill_stall waited %0d cycles want 10..39", waited); end
      tick();
      wr_valid = 1'b0;
      waited = 0;
      while (busy && waited < 200) begin tick(); waited++; end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fill_drain busy=%b want 0", busy); end
      mon_en = 1'b0;
      vectors++; if (seen.size() != 6) begin miscompares++; $display("FAIL fill_count got %0d bytes want 6", seen.size()); end
      for (int i = 0; i < 6 && i < seen.size(); i++) begin
         vectors++; if (seen[i] !== exp_b[i]) begin miscompares++; $display("FAIL fill_order[%0d] got %h want %h", i, seen[i], exp_b[i]); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      wr_hold = 4'd0;
      wr_valid = 1'b1; wr_data = 8'h11;
      tick();
      vectors++; if (drv_byte !== 8'h00 || fifo_level !== 3'd1) begin miscompares++; $display("FAIL b2b_first drv=%h lvl=%0d want 00/1", drv_byte, fifo_level); end
      wr_data = 8'h22;
      tick();
      wr_valid = 1'b0;
      vectors++; if (drv_byte !== 8'h11) begin miscompares++; $display("FAIL b2b_11 got %h want 11", drv_byte); end
      tick();
      vectors++; if (drv_byte !== 8'h22 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_22 drv=%h busy=%b want 22/1", drv_byte, busy); end
      tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle busy=%b want 0", busy); end
   endtask

   task automatic test_unlock();
      logic [7:0] seq [4];
      int waited;
      seq = '{8'h21, 8'hF1, 8'h37, 8'h44};
      do_reset();
      unlock_en = 1'b1;
      wr_hold = 4'd1;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = seq[i];
         tick();
      end
      wr_valid = 1'b0;
      waited = 0;
      while (drv_byte !== 8'h44 && waited < 20) begin tick(); waited++; end
      vectors++; if (status !== STAT_INVERT || unlock_seen !== 1'b0) begin miscompares++; $display("FAIL unlock_pre status=%0d unlock=%b want 1/0", status, unlock_seen); end
      waited = 0;
      while (!unlock_seen && waited < 20) begin tick(); waited++; end
      vectors++; if (unlock_seen !== 1'b1 || status !== STAT_BYPASS) begin miscompares++; $display("FAIL unlock_post unlock=%b status=%0d want 1/2", unlock_seen, status); end
      vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL unlock_no_err got %b want 0", err_sticky); end
   endtask

   task automatic test_error();
      int waited;
      do_reset();
      force_en = 1'b1; force_val = 8'h00;
      wr_hold = 4'd4;
      wr_valid = 1'b1; wr_data = 8'h0F;
      tick();
      wr_valid = 1'b0;
      waited = 0;
      while (!err_sticky && waited < 20) begin tick(); waited++; end
      vectors++; if (status !== STAT_ERROR || err_sticky !== 1'b1) begin miscompares++; $display("FAIL error_set status=%0d err=%b want 3/1", status, err_sticky); end
      force_en = 1'b0;
      repeat (4) tick();
      vectors++; if (status !== STAT_INVERT || err_sticky !== 1'b1) begin miscompares++; $display("FAIL error_persist status=%0d err=%b want 1/1", status, err_sticky); end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      wr_hold = 4'd15;
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = 8'hB1 + 8'(i);
         tick();
      end
      wr_valid = 1'b0;
      repeat (3) tick();
      vectors++; if (fifo_level !== 3'd2 || status !== STAT_INVERT || drv_byte !== 8'hB1) begin miscompares++; $display("FAIL midrst_before lvl=%0d status=%0d drv=%h want 2/1/b1", fifo_level, status, drv_byte); end
      #2 rst = 1'b1;
      #1;
      vectors++; if (drv_byte !== 8'h00 || fifo_level !== 3'd0 || status !== STAT_UNKNOWN) begin miscompares++; $display("FAIL midrst_clear drv=%h lvl=%0d status=%0d want 00/0/0", drv_byte, fifo_level, status); end
      vectors++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_idle busy=%b ready=%b want 0/1", busy, wr_ready); end
      tick();
      rst = 1'b0;
      repeat (3) tick();
      vectors++; if (busy !== 1'b0 || drv_byte !== 8'h00) begin miscompares++; $display("FAIL midrst_after busy=%b drv=%h want 0/00", busy, drv_byte); end
   endtask

   initial begin
      test_reset();
      test_single_hold();
      test_fill_full();
      test_back_to_back();
      test_unlock();
      test_error();
      test_reset_mid_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/crypto_stim_driver.md
Name: crypto_stim_driver

Overview:
- Stimulus source and response checker for the fake_crypto stage.
- Buffers host-written bytes in a small FIFO and drives each onto the crypto `input_` for a programmable number of cycles.
- Watches the crypto `output_` one cycle later and classifies the stage as inverting (locked) or pass-through (unlocked).
- Sits directly upstream (`drv_byte` -> `input_`) and downstream (`output_` -> `resp_byte`) of the crypto stage.

Parameters:
- DEPTH, 4: FIFO entries, power of two, minimum 2.
- HOLD_W, 4: width of the per-byte hold count.
- PRE_HOLD, 2: hold cycles per preload byte (Optional Feature only).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  host offers a byte.
- wr_ready  out  1  FIFO not full.
- wr_data  in  8  byte to drive.
- wr_hold  in  HOLD_W  cycles to present the byte; 0 is treated as 1.
- drv_byte  out  8  to crypto `input_`.
- resp_byte  in  8  from crypto `output_`.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- status  out  2  STAT_UNKNOWN / STAT_INVERT / STAT_BYPASS / STAT_ERROR.
- unlock_seen  out  1  sticky: status went INVERT -> BYPASS.
- err_sticky  out  1  sticky: any STAT_ERROR classification.

Behaviour:
- Reset values (asynchronous):
  - FIFO empty, so `fifo_level` = 0 and `wr_ready` = 1.
  - FSM in IDLE (PRELOAD when macro defined); `drv_byte` = 0x00.
  - `busy` = 0 (1 under macro); `status` = STAT_UNKNOWN; `unlock_seen` = 0; `err_sticky` = 0; compare pipeline invalid.
- Write handshake:
  - Push occurs on `wr_valid && wr_ready`.
  - `wr_ready` = !full, computed from registered occupancy only; a same-cycle pop does not raise it.
  - `wr_data` is ignored when not ready.
- No FIFO bypass. A byte accepted at edge N, with the FSM in IDLE, appears on `drv_byte` after edge N+1.
- FSM states:
  - IDLE: if FIFO non-empty, pop; `drv_byte` <= data; `hold_cnt` <= max(wr_hold,1)-1; go to HOLD. Otherwise `drv_byte` holds its last value.
  - HOLD: if `hold_cnt` != 0, decrement. If `hold_cnt` == 0 and FIFO non-empty, pop the next byte back-to-back (no gap cycle) and stay in HOLD. If `hold_cnt` == 0 and FIFO empty, go to IDLE.
  - PRELOAD: exists only under the macro.
- Simultaneous push and pop when FIFO is full: the push is refused (`wr_ready` = 0); the pop proceeds.
- When the FIFO is empty, a push and an FSM read in the same cycle give no pop that cycle.
- Compare pipeline:
  - `prev_drv` <= `drv_byte` every cycle.
  - `prev_valid` <= 1 once the first byte has been driven for a full cycle. Before that, `status` stays UNKNOWN because crypto `output_` is undefined.
- Classification when `prev_valid` (registered, visible after the edge):
  - `resp_byte` == ~`prev_drv` -> STAT_INVERT.
  - `resp_byte` == `prev_drv` -> STAT_BYPASS.
  - Anything else -> STAT_ERROR, and set `err_sticky`.
  - INVERT and BYPASS never alias: x != ~x for all 8-bit values.
- `unlock_seen` sets when the previous status was INVERT and the new status is BYPASS; it never clears except on rst.
- Reset mid-hold: all of the above state is cleared immediately, including FIFO contents.

Optional Feature:
- Macro: CRYPTO_STIM_PRELOAD_EN.
- Defined:
  - Reset enters PRELOAD, which autonomously drives 0x21, 0xF1, 0x37, 0x00, each held PRE_HOLD cycles.
  - Then go to IDLE. The FIFO accepts writes during PRELOAD but is not popped until PRELOAD completes.
  - The sequence makes the crypto stage unlock via its sequence path; expected result is `unlock_seen` = 1 shortly after preload.
- Not defined: PRELOAD state and constants are absent; reset goes to IDLE.

Decomposition:
- Package crypto_stim_pkg holds:
  - `stat_e` enum: UNKNOWN=0, INVERT=1, BYPASS=2, ERROR=3.
  - Localparams UNLOCK_B0=8'h21, UNLOCK_B1=8'hF1, UNLOCK_B2=8'h37, UNLOCK_TERM=8'h00.
- Sub-module stim_fifo:
  - Synchronous FIFO: DEPTH x (8+HOLD_W), async active-high reset.
  - push/pop/full/empty/level ports.
  - Pointers wrap modulo DEPTH; one extra occupancy bit distinguishes full from empty.

Test Plan:
- Reset then push 0x5A with hold=3, `resp_byte` = ~`drv_byte` model -> `drv_byte` = 0x5A for exactly 3 cycles starting edge N+1; `status` = INVERT from the cycle after; `busy` falls after the hold ends.
- Push 5 bytes back-to-back (DEPTH=4) with the FSM stalled on hold=15 -> `wr_ready` = 0 at level 4; the 5th byte is accepted only after the first pop; no byte lost or duplicated.
- Push 0x11, 0x22 with hold=0 each -> each byte is driven exactly 1 cycle, consecutively with no gap.
- Model unlock: drive 0x21, 0xF1, 0x37, 0x44 with the crypto model switching to pass-through after 0x44 -> `status` INVERT -> BYPASS; `unlock_seen` = 1.
- Force `resp_byte` = 0x00 while `drv_byte` = 0x0F -> STAT_ERROR and `err_sticky` = 1; `err_sticky` persists after correct responses resume.
- Assert rst during HOLD with 2 bytes queued -> immediately `drv_byte` = 0, `fifo_level` = 0, `status` = UNKNOWN; with CRYPTO_STIM_PRELOAD_EN, the preload sequence restarts after rst release.
